load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Executes one data-memory access per request, driven by the decoder outputs MemWr, MemOp and MemtoReg, with the ALU result as the address and rs2 as store data.
- Generates byte-lane strobes and replicated store data, and drives a valid/grant/rvalid data bus.
- Sign- or zero-extends load data.
- Flags illegal ops, misalignment and bus timeout; stalls the core via req_ready.

Parameters:
- TIMEOUT, 255: max cycles waiting in REQ or WAIT before a bus-timeout error; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request (decoder asserted MemWr or MemtoReg).
- req_ready  out  1  high when idle; request accepted on req_valid & req_ready.
- MemWr  in  1  1 = store, 0 = load.
- MemOp  in  3  000 b, 001 bu, 010 h, 011 hu, 100 w.
- addr  in  32  byte address (rs1 + imm).
- wdata  in  32  store data (rs2).
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid with done.
- err  out  1  qualifies done.
- err_code  out  2  00 none, 01 misaligned, 10 illegal MemOp, 11 bus timeout.
- mem_req  out  1  bus request, held until granted.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  word address, with [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  bus accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n = 0):
  - State is IDLE and req_ready = 1.
  - All other outputs are 0, including done, err, err_code, rdata and mem_*.
  - Reset mid-access drops mem_req immediately and produces no done.
- States: IDLE, REQ, WAIT. All outputs are registered except req_ready = (state == IDLE).
- Accept at cycle T (IDLE with req_valid = 1): latch op, addr[1:0], MemWr.
- Checks, in priority order:
  - Illegal op: MemOp > 100 for loads; MemOp in {001, 011, 101, 110, 111} for stores. Response: code 10.
  - Misaligned: h/hu with addr[0] = 1, or w with addr[1:0] != 00. Response: code 01.
  - Error handling: at T+1 done = 1, err = 1 and rdata = 0. State stays IDLE, no bus activity.
- Legal request: at T+1 enter REQ with mem_req = 1.
  - mem_addr = {addr[31:2], 2'b00}.
  - mem_we = MemWr.
  - Timeout counter = 0.
- Byte lanes:
  - b/bu: mem_be = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - h/hu: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - w: mem_be = 1111; mem_wdata = wdata.
  - Loads drive mem_be identically, as read strobes.
- REQ:
  - mem_* are stable until mem_gnt.
  - On mem_gnt with a store: mem_req falls, done = 1 next cycle, state returns to IDLE.
  - On mem_gnt with a load: mem_req falls, state goes to WAIT, counter clears.
- WAIT:
  - On mem_rvalid: rdata = lane extracted by addr[1:0].
    - b: sign-extended bit 7.
    - bu: zero-extended.
    - h: sign-extended bit 15.
    - hu: zero-extended.
    - w: raw word.
  - done = 1 next cycle, then IDLE.
- mem_rvalid outside WAIT is ignored, including in the grant cycle. The bus guarantees rvalid at least 1 cycle after gnt.
- Minimum latencies from the accept cycle T:
  - Store: done at T+2 (gnt at T+1).
  - Load: done at T+3 (gnt at T+1, rvalid at T+2).
- Back-to-back: req_ready = 1 in the done cycle, so a new request may be accepted then.
- Timeout:
  - The counter increments each cycle in REQ/WAIT.
  - When count == TIMEOUT without gnt/rvalid: mem_req falls; done, err and code 11 are asserted; rdata = 0; state returns to IDLE.
  - gnt/rvalid in the limit cycle wins over timeout.
  - A late rvalid after timeout is ignored.
- Hold rules:
  - rdata holds its value until the next done.
  - err/err_code are valid only with done and are 0 otherwise.
  - req_valid while busy is ignored.

Decomposition:
- Package lsu_pkg holds:
  - MEMOP_B/BU/H/HU/W encodings.
  - ERR_NONE/MISALIGN/ILLEGAL/TIMEOUT codes.
  - The state enum.
- Sub-module lsu_lane: combinational.
  - Inputs: op, addr[1:0], wdata.
  - Outputs: be, replicated wdata, legal, aligned flags.
  - Also performs load extraction/extension from rdata.
- The FSM, counter and registers live in load_store_unit.

Test Plan:
- Store sb: addr = 0x1003, wdata = 0xAABBCCDD, gnt on the first REQ cycle -> mem_be = 1000, mem_wdata = 0xDDDDDDDD, mem_addr = 0x1000, mem_we = 1; done at T+2 with err = 0.
- Load lb/lbu: addr = 0x2001, mem_rdata = 0x1234F678, rvalid one cycle after gnt -> lb gives rdata = 0xFFFFFFF6; lbu gives 0x000000F6; done at T+3.
- Load lh: addr = 0x2002, mem_rdata = 0x8001_0000 -> rdata = 0xFFFF8001, mem_be = 1100.
- Errors, no mem_req ever raised:
  - lw at addr = 0x2002 -> done at T+1, err = 1, code 01.
  - Store with MemOp = 001 -> code 10.
- Timeout: TIMEOUT = 4, gnt held low -> mem_req high for 5 cycles, then done, err = 1, code 11, IDLE; a later rvalid is ignored.
- Back-to-back and reset:
  - Accept a second request in the done cycle; both complete in order.
  - Assert rst_n = 0 in WAIT -> mem_req = 0, no done; after release, req_ready = 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: memory-op codes, error codes and FSM states.
// No logic; imported by lsu_lane and load_store_unit.
package lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_BU = 3'b001;
  localparam logic [2:0] MEMOP_H  = 3'b010;
  localparam logic [2:0] MEMOP_HU = 3'b011;
  localparam logic [2:0] MEMOP_W  = 3'b100;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: strobes, store-data replication, legality/alignment and load extraction.
// Purely combinational (0 cycles); no flow control of its own.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic        store_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        legal_o,
  output logic        aligned_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o      = 4'b0000;
    wdata_o   = wdata_i;
    legal_o   = 1'b0;
    aligned_o = 1'b1;
    rdata_o   = 32'd0;
    case (op_i)
      MEMOP_B, MEMOP_BU: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        // Unsigned variants only make sense for loads.
        legal_o = !(store_i && (op_i == MEMOP_BU));
        rdata_o = (op_i == MEMOP_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      end
      MEMOP_H, MEMOP_HU: begin
        be_o      = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
        legal_o   = !(store_i && (op_i == MEMOP_HU));
        aligned_o = !off_i[0];
        rdata_o   = (op_i == MEMOP_H) ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      end
      MEMOP_W: begin
        be_o      = 4'b1111;
        legal_o   = 1'b1;
        aligned_o = (off_i == 2'b00);
        rdata_o   = rdata_i;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// One data-memory access per request over a req/gnt/rvalid bus; store done at T+2, load at T+3 minimum, errors at T+1.
// Backpressure: req_ready is low while an access is in flight; mem_req holds until gnt or timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemWr,
  input  logic [2:0]  MemOp,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  lsu_state_e       state_q;
  logic [2:0]       op_q;
  logic [1:0]       off_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, err_q;
  logic [1:0]       err_code_q;
  logic [31:0]      rdata_q;
  logic             mem_req_q, mem_we_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_be_q;

  logic [2:0]  lane_op;
  logic [1:0]  lane_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic        lane_legal, lane_aligned;
  logic        timeout_hit;

  // The lane block decodes the incoming request while idle and the latched op while waiting for data.
  assign lane_op     = (state_q == ST_IDLE) ? MemOp : op_q;
  assign lane_off    = (state_q == ST_IDLE) ? addr[1:0] : off_q;
  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_CNT);

  lsu_lane u_lane (
    .op_i      (lane_op),
    .store_i   (MemWr),
    .off_i     (lane_off),
    .wdata_i   (wdata),
    .rdata_i   (mem_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .legal_o   (lane_legal),
    .aligned_o (lane_aligned),
    .rdata_o   (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q  <= MemOp;
            off_q <= addr[1:0];
            we_q  <= MemWr;
            if (!lane_legal || !lane_aligned) begin
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= !lane_legal ? ERR_ILLEGAL : ERR_MISALIGN;
              rdata_q    <= 32'd0;
            end else begin
              state_q     <= ST_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= MemWr;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_be_q    <= lane_be;
              mem_wdata_q <= lane_wdata;
              cnt_q       <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            if (we_q) begin
              done_q  <= 1'b1;
              rdata_q <= 32'd0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT;
            end
          end else if (timeout_hit) begin
            mem_req_q  <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            rdata_q    <= 32'd0;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= lane_rdata;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (timeout_hit) begin
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            rdata_q    <= 32'd0;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected completions, a negedge monitor checks them.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        MemWr = 1'b0;
  logic [2:0]  MemOp = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  load_store_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .MemWr(MemWr), .MemOp(MemOp), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .err(err), .err_code(err_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        err;
    logic [1:0]  code;
    logic [31:0] rdata;
    bit          chk_rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.name, "_err"}, 32'(err), 32'(e.err));
        chk({e.name, "_code"}, 32'(err_code), 32'(e.code));
        if (e.chk_rd) chk({e.name, "_rdata"}, rdata, e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request in the current cycle (T); returns at T+1.
  task automatic issue(input string name, input logic we, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input bit push,
                       input logic e_err, input logic [1:0] e_code,
                       input logic [31:0] e_rd, input bit chk_rd, input int lat);
    exp_t e;
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; MemWr = we; MemOp = op; addr = a; wdata = wd;
    if (push) begin
      e.name = name; e.err = e_err; e.code = e_code;
      e.rdata = e_rd; e.chk_rd = chk_rd; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    tick();
    req_valid = 1'b0; MemWr = 1'b0; MemOp = 3'd0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic store_seq(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] e_be, input logic [31:0] e_wd);
    logic [31:0] waddr;
    waddr = {a[31:2], 2'b00};
    issue(name, 1'b1, op, a, wd, 1'b1, 1'b0, ERR_NONE, 32'd0, 1'b0, 2);
    chk({name, "_mem_req"}, 32'(mem_req), 32'd1);
    chk({name, "_mem_we"}, 32'(mem_we), 32'd1);
    chk({name, "_mem_be"}, 32'(mem_be), 32'(e_be));
    chk({name, "_mem_wdata"}, mem_wdata, e_wd);
    chk({name, "_mem_addr"}, mem_addr, waddr);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({name, "_req_drop"}, 32'(mem_req), 32'd0);
    tick();
  endtask

  // Load with gnt at T+1 (junk rvalid in the grant cycle) and real rvalid at T+2.
  task automatic load_seq(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] rd, input logic [3:0] e_be, input logic [31:0] e_rd);
    issue(name, 1'b0, op, a, 32'd0, 1'b1, 1'b0, ERR_NONE, e_rd, 1'b1, 3);
    chk({name, "_mem_be"}, 32'(mem_be), 32'(e_be));
    chk({name, "_mem_we"}, 32'(mem_we), 32'd0);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    tick();
  endtask

  task automatic err_seq(input string name, input logic we, input logic [2:0] op,
                         input logic [31:0] a, input logic [1:0] code);
    issue(name, we, op, a, 32'h55555555, 1'b1, 1'b1, code, 32'd0, 1'b1, 1);
    chk({name, "_no_mem_req"}, 32'(mem_req), 32'd0);
    tick();
  endtask

  initial begin
    int hi;
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_ctrl", 32'({done, err, err_code, mem_req, mem_we, mem_be}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();

    store_seq("sb", MEMOP_B, 32'h0000_1003, 32'hAABBCCDD, 4'b1000, 32'hDDDDDDDD);
    store_seq("sh", MEMOP_H, 32'h0000_1002, 32'h11223344, 4'b1100, 32'h33443344);
    store_seq("sw", MEMOP_W, 32'h0000_1004, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    load_seq("lb",  MEMOP_B,  32'h0000_2001, 32'h1234F678, 4'b0010, 32'hFFFFFFF6);
    load_seq("lbu", MEMOP_BU, 32'h0000_2001, 32'h1234F678, 4'b0010, 32'h000000F6);
    load_seq("lb3", MEMOP_B,  32'h0000_2003, 32'h80000000, 4'b1000, 32'hFFFFFF80);
    load_seq("lh",  MEMOP_H,  32'h0000_2002, 32'h80010000, 4'b1100, 32'hFFFF8001);
    load_seq("lhu", MEMOP_HU, 32'h0000_2000, 32'h1234F678, 4'b0011, 32'h0000F678);
    load_seq("lw",  MEMOP_W,  32'h0000_2004, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF);

    err_seq("lw_misal",   1'b0, MEMOP_W,  32'h0000_2002, ERR_MISALIGN);
    err_seq("lh_misal",   1'b0, MEMOP_H,  32'h0000_2001, ERR_MISALIGN);
    err_seq("st_op001",   1'b1, MEMOP_BU, 32'h0000_1000, ERR_ILLEGAL);
    err_seq("ld_op101",   1'b0, 3'b101,   32'h0000_1000, ERR_ILLEGAL);
    err_seq("st_op011_odd", 1'b1, MEMOP_HU, 32'h0000_1001, ERR_ILLEGAL);

    // Timeout in REQ: mem_req stays up for TIMEOUT+1 cycles, then error completion.
    issue("to_req", 1'b0, MEMOP_W, 32'h0000_3000, 32'd0, 1'b1, 1'b1, ERR_TIMEOUT, 32'd0, 1'b1, 6);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      hi += int'(mem_req);
      tick();
    end
    chk("to_req_high_cycles", 32'(hi), 32'd5);
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_req_idle", 32'(req_ready), 32'd1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    tick();

    // Timeout in WAIT: counter restarts at grant.
    issue("to_wait", 1'b0, MEMOP_W, 32'h0000_3004, 32'd0, 1'b1, 1'b1, ERR_TIMEOUT, 32'd0, 1'b1, 7);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Grant in the limit cycle beats the timeout.
    issue("gnt_limit", 1'b1, MEMOP_W, 32'h0000_3008, 32'h0BADF00D, 1'b1, 1'b0, ERR_NONE, 32'd0, 1'b0, 6);
    for (int i = 0; i < 4; i++) tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();

    // Back-to-back: second request accepted in the first one's done cycle.
    issue("b2b_sw", 1'b1, MEMOP_W, 32'h0000_4000, 32'h01020304, 1'b1, 1'b0, ERR_NONE, 32'd0, 1'b0, 2);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("b2b_done_cycle_ready", 32'(req_ready & done), 32'd1);
    issue("b2b_lbu", 1'b0, MEMOP_BU, 32'h0000_4001, 32'd0, 1'b1, 1'b0, ERR_NONE, 32'h000000AB, 1'b1, 3);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000AB00;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    tick();

    // Reset while in REQ drops mem_req asynchronously.
    issue("rst_req", 1'b0, MEMOP_W, 32'h0000_5000, 32'd0, 1'b0, 1'b0, ERR_NONE, 32'd0, 1'b0, 0);
    chk("rst_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_req_async_drop", 32'(mem_req), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    tick();

    // Reset while in WAIT: no completion, late rvalid ignored.
    issue("rst_wait", 1'b0, MEMOP_W, 32'h0000_5004, 32'd0, 1'b0, 1'b0, ERR_NONE, 32'd0, 1'b0, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wait_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rst_wait_ready", 32'(req_ready), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    for (int i = 0; i < 3; i++) tick();

    chk("all_completions_seen", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
